// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit for the EX stage. It takes one request
// at a time over a valid/ready handshake. Multiplies use radix-2 shift-add and
// divides use restoring division. Both run for WIDTH iterations on magnitudes,
// and the sign is corrected when the result is registered. The result is held
// until the consumer takes it.
//
// Optional feature: define MULDIV_RESULT_REUSE_EN to keep a one-entry tag of
// the last completed operation. The tag holds the class, both operands and both
// result halves. A later request with the same class and operands then
// completes in a single edge.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of the in-flight operation (highest priority)
//   in_valid   request valid
//   in_ready   unit can accept (IDLE only, decoded from state)
//   op         RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   operand1   rs1 / dividend
//   operand2   rs2 / divisor
//   out_valid  result valid (DONE)
//   out_ready  consumer takes the result
//   result     registered result
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // operand1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_signed(input logic [2:0] f);
        if (f[2]) return ~f[0];
        return (f[1:0] == 2'b01) || (f[1:0] == 2'b10);
    endfunction

    // operand2 is signed for MULH, DIV and REM.
    function automatic logic b_signed(input logic [2:0] f);
        if (f[2]) return ~f[0];
        return (f[1:0] == 2'b01);
    endfunction

    // Both halves are carried as (hi, lo). For a multiply that is the product,
    // and for a divide it is (quotient, remainder). MUL, REM and REMU return lo.
    function automatic logic [WIDTH-1:0] pick(input logic [2:0] f,
                                              input logic [WIDTH-1:0] hi,
                                              input logic [WIDTH-1:0] lo);
        logic sel_lo;
        sel_lo = f[2] ? f[1] : (f[1:0] == 2'b00);
        return sel_lo ? lo : hi;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;     // product high half / partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;     // multiplier bits / dividend-quotient
    logic [WIDTH-1:0]   b_q, b_d;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   result_q, result_d;

    // Request decode
    logic               accept;
    logic               a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    logic               div_zero_in, div_ovf_in;

    // One iteration step
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   div_rem_nx, div_quo_nx;

    // Sign-corrected final halves
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   calc_hi, calc_lo;

    // Result load (entry to DONE)
    logic               load_en;
    logic [2:0]         load_op;
    logic [WIDTH-1:0]   load_hi, load_lo;

    // Reuse tag lookup
    logic               reuse_hit;
    logic [WIDTH-1:0]   reuse_hi, reuse_lo;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    assign accept      = (state_q == IDLE) && in_valid && !flush;
    assign a_neg_in    = a_signed(op) & operand1[WIDTH-1];
    assign b_neg_in    = b_signed(op) & operand2[WIDTH-1];
    // The magnitude of MIN is MIN itself when read as unsigned, so no overflow.
    assign a_mag_in    = a_neg_in ? -operand1 : operand1;
    assign b_mag_in    = b_neg_in ? -operand2 : operand2;
    assign div_zero_in = op[2] && (operand2 == '0);
    assign div_ovf_in  = op[2] && !op[0] && (operand1 == MIN_VAL) && (operand2 == ALL_ONES);

    // Shift-add: conditionally add the multiplicand into the high half, then
    // shift the {carry, hi, lo} pair right by one.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring division: shift the next dividend bit into the remainder and
    // keep the difference only if it did not go negative.
    assign div_shift  = {hi_q, lo_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, b_q};
    assign q_bit      = ~div_diff[WIDTH];
    assign div_rem_nx = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_nx = {lo_q[WIDTH-2:0], q_bit};

    assign prod     = {mul_hi_nx, mul_lo_nx};
    assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    assign quo_fix  = (a_neg_q ^ b_neg_q) ? -div_quo_nx : div_quo_nx;
    assign rem_fix  = a_neg_q ? -div_rem_nx : div_rem_nx;   // remainder follows the dividend
    assign calc_hi  = op_q[2] ? quo_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign calc_lo  = op_q[2] ? rem_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        load_en  = 1'b0;
        load_op  = op_q;
        load_hi  = '0;
        load_lo  = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    hi_d    = '0;
                    lo_d    = a_mag_in;
                    b_d     = b_mag_in;
                    cnt_d   = '0;
                    load_op = op;
                    if (div_zero_in) begin
                        load_en = 1'b1;
                        load_hi = ALL_ONES;
                        load_lo = operand1;
                        state_d = DONE;
                    end else if (div_ovf_in) begin
                        load_en = 1'b1;
                        load_hi = MIN_VAL;
                        load_lo = '0;
                        state_d = DONE;
                    end else if (reuse_hit) begin
                        load_en = 1'b1;
                        load_hi = reuse_hi;
                        load_lo = reuse_lo;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = op_q[2] ? div_rem_nx : mul_hi_nx;
                    lo_d  = op_q[2] ? div_quo_nx : mul_lo_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        load_en = 1'b1;
                        load_hi = calc_hi;
                        load_lo = calc_lo;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            result_d = pick(load_op, load_hi, load_lo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

`ifdef MULDIV_RESULT_REUSE_EN
    // Class = {is_div, operand1 signed, operand2 signed}. MUL shares the
    // unsigned class with MULHU because its low half does not depend on sign.
    logic             rr_valid_q;
    logic [2:0]       rr_class_q;
    logic [WIDTH-1:0] rr_a_q, rr_b_q, rr_hi_q, rr_lo_q;
    logic [WIDTH-1:0] a_raw_q, b_raw_q;   // original operands of the op in CALC
    logic [2:0]       in_class, load_class;

    assign in_class   = {op[2], a_signed(op), b_signed(op)};
    assign load_class = {load_op[2], a_signed(load_op), b_signed(load_op)};
    assign reuse_hit  = rr_valid_q && (in_class == rr_class_q) &&
                        (operand1 == rr_a_q) && (operand2 == rr_b_q);
    assign reuse_hi   = rr_hi_q;
    assign reuse_lo   = rr_lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_valid_q <= 1'b0;
            rr_class_q <= '0;
            rr_a_q     <= '0;
            rr_b_q     <= '0;
            rr_hi_q    <= '0;
            rr_lo_q    <= '0;
            a_raw_q    <= '0;
            b_raw_q    <= '0;
        end else begin
            if (accept) begin
                a_raw_q <= operand1;
                b_raw_q <= operand2;
            end
            if (flush) begin
                rr_valid_q <= 1'b0;
            end else if (load_en) begin
                // A load straight from IDLE carries the live operands.
                rr_valid_q <= 1'b1;
                rr_class_q <= load_class;
                rr_a_q     <= (state_q == IDLE) ? operand1 : a_raw_q;
                rr_b_q     <= (state_q == IDLE) ? operand2 : b_raw_q;
                rr_hi_q    <= load_hi;
                rr_lo_q    <= load_lo;
            end
        end
    end
`else
    assign reuse_hit = 1'b0;
    assign reuse_hi  = '0;
    assign reuse_lo  = '0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32).
// The stimulus pushes the expected result and latency when a request is
// accepted. A monitor pops one entry on every rising out_valid and compares.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_RESULT_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 33;
`endif
    localparam int NORM_LAT = 33;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got %h ok", nm, act);
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per rising out_valid, sampled on negedge.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected out_valid", {31'b0, out_valid}, '0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " result"}, result, e.res);
                    chk({e.name, " latency"}, W'(cycle - e.acc + 1), W'(e.lat));
                end
            end
            prev_valid = out_valid;
        end
    end

    // Issue one request; accept happens on the edge after the negedge that
    // drives it, because in_ready depends only on the current state.
    task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                         input bit push);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk({nm, " in_ready timeout"}, {31'b0, in_ready}, 1);
            return;
        end
        in_valid = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        if (push) begin
            e.res = exp; e.lat = lat; e.acc = cycle + 1; e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || !in_ready)
            chk({nm, " drain timeout"}, W'(sb.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: cycle %0d expected finish", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        #3;
        chk("reset in_ready", {31'b0, in_ready}, 1);
        chk("reset out_valid", {31'b0, out_valid}, 0);
        chk("reset result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("MUL 7*6",          OP_MUL,    32'd7,        32'd6,        32'd42,       NORM_LAT,  1);
        issue("MULHU ff*ff",      OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NORM_LAT,  1);
        issue("MUL ff*ff",        OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, REUSE_LAT, 1);
        issue("MULHSU ff*ff",     OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, NORM_LAT,  1);
        issue("MULH min*min",     OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, NORM_LAT,  1);
        issue("DIV -7/2",         OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NORM_LAT,  1);
        issue("REM -7%2",         OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, REUSE_LAT, 1);
        issue("DIV 100/-7",       OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, NORM_LAT,  1);
        issue("DIVU 100/7",       OP_DIVU,   32'd100,      32'd7,        32'd14,       NORM_LAT,  1);
        issue("REMU 100%7",       OP_REMU,   32'd100,      32'd7,        32'd2,        REUSE_LAT, 1);
        issue("DIV 5/0",          OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,         1);
        issue("REM 5%0",          OP_REM,    32'd5,        32'd0,        32'd5,        1,         1);
        issue("DIV min/-1",       OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,         1);
        issue("REM min%-1",       OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,         1);
        drain("directed");

        // Backpressure: result and out_valid held, new request ignored.
        out_ready = 1'b0;
        issue("BP MUL 7*6", OP_MUL, 32'd7, 32'd6, 32'd42, NORM_LAT, 1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp out_valid seen", {31'b0, out_valid}, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                in_valid = 1'b1; op = OP_MUL; operand1 = 32'd3; operand2 = 32'd3;
            end
            if (i == 4) in_valid = 1'b0;
            chk("bp result held", result, 32'd42);
            chk("bp out_valid held", {31'b0, out_valid}, 1);
            chk("bp in_ready low", {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp idle in_ready", {31'b0, in_ready}, 1);
        chk("bp idle out_valid", {31'b0, out_valid}, 0);

        // Flush at CALC iteration 10.
        issue("FLUSH DIVU", OP_DIVU, 32'd1000, 32'd3, '0, 0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush in_ready", {31'b0, in_ready}, 1);
        chk("flush out_valid", {31'b0, out_valid}, 0);
        chk("flush result kept", result, 32'd42);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-CALC.
        issue("RST DIVU", OP_DIVU, 32'd1000, 32'd7, '0, 0, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst in_ready", {31'b0, in_ready}, 1);
        chk("rst out_valid", {31'b0, out_valid}, 0);
        chk("rst result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Reuse: DIV then REM on the same operands; a flush clears the tag.
        issue("RU DIV 100/7",  OP_DIV, 32'd100, 32'd7, 32'd14, NORM_LAT,  1);
        issue("RU REM 100%7",  OP_REM, 32'd100, 32'd7, 32'd2,  REUSE_LAT, 1);
        issue("RU DIV again",  OP_DIV, 32'd100, 32'd7, 32'd14, REUSE_LAT, 1);
        drain("reuse");
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        issue("RU REM after flush", OP_REM, 32'd100, 32'd7, 32'd2, NORM_LAT, 1);
        drain("final");

        chk("scoreboard empty", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, iterative RV32M multiply/divide unit that sits beside the single-cycle integer ALU in the EX stage. It uses a valid/ready handshake. It accepts one operation at a time and computes it over WIDTH cycles using radix-2 shift-add (multiply) or restoring division (divide). It holds the result until the pipeline consumes it. Hazard logic stalls the pipeline on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the in-flight operation (branch/exception).
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op`  in  3  RV32M funct3:
  - 000 MUL
  - 001 MULH
  - 010 MULHSU
  - 011 MULHU
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- `operand1`  in  WIDTH  rs1 value / dividend.
- `operand2`  in  WIDTH  rs2 value / divisor.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: iterating.
  - DONE: `out_valid`=1.
- Accept on a rising edge with `in_valid && in_ready`. At accept, capture `op`, the operands, and the operand signs.
- Operand signedness:
  - Signed: MULH and DIV/REM treat both operands as signed.
  - Mixed: MULHSU treats only `operand1` as signed.
  - Unsigned: all other ops.
- Signed operands are converted to magnitudes at accept. The sign is fixed up when CALC→DONE, with the result registered.
- Multiply produces a full 2·WIDTH product.
  - MUL returns the low WIDTH bits.
  - MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Special divide cases bypass CALC and go IDLE→DONE directly:
  - Divisor 0: quotient = all ones; remainder = `operand1`.
  - Signed overflow (`operand1`=MIN, `operand2`=−1): quotient = MIN; remainder = 0.
- DONE→IDLE on `out_ready`. A new request can then be accepted on the following edge; back-to-back accept in the same cycle as the handshake is not allowed.
- `flush`:
  - In CALC or DONE: go to IDLE, drop `out_valid`, leave `result` unchanged.
  - In IDLE: suppresses the accept.
  - `flush` has priority over every other event.
- `in_valid` is ignored outside IDLE.

## Timing
- Reset values:
  - `out_valid`=0, `result`=0, `in_ready`=1.
  - State = IDLE; counter = 0.
  - Reuse tag invalid.
- `rst_n` low mid-operation returns to IDLE immediately (asynchronous) and discards the operation.
- Normal latency: `out_valid` rises WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
  - 1 edge: accept → CALC.
  - WIDTH iterations.
  - The final iteration's edge enters DONE with `result` loaded.
- Special-case divide latency: 1 edge after accept.
- While `out_valid`=1 and `out_ready`=0, `result` and `out_valid` are held stable.
- `in_ready` is combinational from state only, with no input-to-output path.

## Configuration
- `MULDIV_RESULT_REUSE_EN` defined:
  - On every entry to DONE, the unit stores the operation class (mul-signedness or div-signedness), both operands, and both halves of the result. The halves are the full product, or quotient and remainder.
  - A later request with the same class and operands completes in 1 edge from the stored copy, without entering CALC. Examples: DIV then REM; MULHU then MUL with matching signedness for the high half.
  - The tag is invalidated by `flush` and by reset.
- Not defined: no tag storage, and every request follows the normal latency.

## Test plan
- MUL 7, 6 → `result`=42, `out_valid` 33 edges after accept. MULHU 0xFFFFFFFF, 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF, 0xFFFFFFFF → 0xFFFFFFFF. MULH 0x80000000, 0x80000000 → 0x40000000.
- DIV 0xFFFFFFF9 (−7), 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100, 7 → 14. REMU 100, 7 → 2.
- DIV 5, 0 → 0xFFFFFFFF in 1 edge. REM 5, 0 → 5. DIV 0x80000000, 0xFFFFFFFF → 0x80000000. REM same operands → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `result` stable, `in_ready`=0, and a new `in_valid` is ignored. Then raise `out_ready` → IDLE next edge.
- `flush` at CALC iteration 10 → IDLE next edge, no `out_valid`. Separately, `rst_n` pulsed low mid-CALC → all outputs at reset values immediately.
- DIV 100, 7 then REM 100, 7 → REM returns 2 in 1 edge with `MULDIV_RESULT_REUSE_EN`, and 33 edges without. A `flush` between the two forces 33 edges in both builds.
